// File: rtl/dlx_decode_stage.sv
// dlx_decode_stage -- registered DLX instruction-decode stage between IF and EX.
//
// Takes one instruction per cycle over a valid/ready handshake, decodes it into
// EX control fields and holds them in an output register (1-cycle latency).
// A load followed by a dependent instruction gets one bubble. Flush drops the
// held bundle and any instruction offered in the same cycle. Unknown encodings
// come out with only `illegal` set.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   in_valid/in_ready       IF -> ID handshake; in_instr, in_pc are the payload
//   flush                   discard held and incoming instruction
//   out_valid/out_ready     ID -> EX handshake
//   out_pc, alu_op, rs1, rs2, rd, imm, imm_sel, mem_rd, mem_wr,
//   br_eqz, br_nez, jmp_abs, jmp_reg, illegal   decoded bundle
//   bubble_cnt              saturating count of inserted load-use bubbles
module dlx_decode_stage #(
  parameter int XLEN           = 32,
  parameter int LINK_REG       = 31,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       alu_op,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic             imm_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             br_eqz,
  output logic             br_nez,
  output logic             jmp_abs,
  output logic             jmp_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            imm_sel;
    logic            mem_rd;
    logic            mem_wr;
    logic            br_eqz;
    logic            br_nez;
    logic            jmp_abs;
    logic            jmp_reg;
    logic            illegal;
  } bundle_t;

  bundle_t          dec_d, bnd_q;
  logic             out_valid_q;
  logic             ld_pend_q, ld_pend_d;
  logic [4:0]       ld_rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             use_rs1, use_rs2, is_ld, legal;
  logic [5:0]       op, fn;
  logic [XLEN-1:0]  sext16, zext16, sext26;
  logic             src_hit, hazard, slot_free, accept;

  assign op     = in_instr[31:26];
  assign fn     = in_instr[5:0];
  assign sext16 = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
  assign zext16 = {{(XLEN-16){1'b0}}, in_instr[15:0]};
  assign sext26 = {{(XLEN-26){in_instr[25]}}, in_instr[25:0]};

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec_d    = '0;
    dec_d.pc = in_pc;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    is_ld    = 1'b0;
    legal    = 1'b1;
    case (op)
      6'h00: begin
        dec_d.rs1 = in_instr[25:21];
        dec_d.rs2 = in_instr[20:16];
        dec_d.rd  = in_instr[15:11];
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        case (fn)
          6'h20:   dec_d.alu_op = 5'd1;
          6'h22:   dec_d.alu_op = 5'd2;
          6'h24:   dec_d.alu_op = 5'd3;
          6'h25:   dec_d.alu_op = 5'd4;
          6'h26:   dec_d.alu_op = 5'd5;
          6'h04:   dec_d.alu_op = 5'd6;
          6'h06:   dec_d.alu_op = 5'd7;
          6'h28:   dec_d.alu_op = 5'd10;
          6'h2c:   dec_d.alu_op = 5'd11;
          6'h2a:   dec_d.alu_op = 5'd12;
          6'h29:   dec_d.alu_op = 5'd13;
          6'h07:   dec_d.alu_op = 5'd14;
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h0a, 6'h18, 6'h1c, 6'h1a, 6'h19,
      6'h0c, 6'h0d, 6'h0e, 6'h14, 6'h16, 6'h17, 6'h0f: begin
        dec_d.rs1     = in_instr[25:21];
        dec_d.rd      = in_instr[20:16];
        dec_d.imm_sel = 1'b1;
        dec_d.imm     = zext16;
        use_rs1       = 1'b1;
        case (op)
          6'h08:   begin dec_d.alu_op = 5'd1;  dec_d.imm = sext16; end
          6'h0a:   begin dec_d.alu_op = 5'd2;  dec_d.imm = sext16; end
          6'h18:   begin dec_d.alu_op = 5'd10; dec_d.imm = sext16; end
          6'h1c:   begin dec_d.alu_op = 5'd11; dec_d.imm = sext16; end
          6'h1a:   begin dec_d.alu_op = 5'd12; dec_d.imm = sext16; end
          6'h19:   begin dec_d.alu_op = 5'd13; dec_d.imm = sext16; end
          6'h0c:   dec_d.alu_op = 5'd3;
          6'h0d:   dec_d.alu_op = 5'd4;
          6'h0e:   dec_d.alu_op = 5'd5;
          6'h14:   dec_d.alu_op = 5'd6;
          6'h16:   dec_d.alu_op = 5'd7;
          6'h17:   dec_d.alu_op = 5'd14;
          default: dec_d.alu_op = 5'd0;   // LHI
        endcase
      end
      6'h23: begin  // LW
        dec_d.alu_op  = 5'd1;
        dec_d.rs1     = in_instr[25:21];
        dec_d.rd      = in_instr[20:16];
        dec_d.imm     = sext16;
        dec_d.imm_sel = 1'b1;
        dec_d.mem_rd  = 1'b1;
        use_rs1       = 1'b1;
        is_ld         = 1'b1;
      end
      6'h2b: begin  // SW: rs2 carries the store data
        dec_d.alu_op  = 5'd1;
        dec_d.rs1     = in_instr[25:21];
        dec_d.rs2     = in_instr[20:16];
        dec_d.imm     = sext16;
        dec_d.imm_sel = 1'b1;
        dec_d.mem_wr  = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      6'h04, 6'h05: begin  // BEQZ/BNEZ: ALU tests rs1, imm is the PC offset
        dec_d.alu_op = (op == 6'h04) ? 5'd8 : 5'd9;
        dec_d.rs1    = in_instr[25:21];
        dec_d.imm    = sext16;
        dec_d.br_eqz = (op == 6'h04);
        dec_d.br_nez = (op == 6'h05);
        use_rs1      = 1'b1;
      end
      6'h12, 6'h13: begin  // JR/JALR
        dec_d.alu_op  = (op == 6'h13) ? 5'd15 : 5'd0;
        dec_d.rs1     = in_instr[25:21];
        dec_d.rd      = (op == 6'h13) ? 5'(LINK_REG) : 5'd0;
        dec_d.jmp_reg = 1'b1;
        use_rs1       = 1'b1;
      end
      6'h02, 6'h03: begin  // J/JAL
        dec_d.alu_op  = (op == 6'h03) ? 5'd15 : 5'd0;
        dec_d.rd      = (op == 6'h03) ? 5'(LINK_REG) : 5'd0;
        dec_d.imm     = sext26;
        dec_d.jmp_abs = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // illegal encodings carry no controls and no register reads
    if (!legal) begin
      dec_d         = '0;
      dec_d.pc      = in_pc;
      dec_d.illegal = 1'b1;
      use_rs1       = 1'b0;
      use_rs2       = 1'b0;
      is_ld         = 1'b0;
    end
  end

  // ------------------------------------------------------- hazard/handshake
  assign src_hit = ld_pend_q &&
                   ((use_rs1 && dec_d.rs1 != 5'd0 && dec_d.rs1 == ld_rd_q) ||
                    (use_rs2 && dec_d.rs2 != 5'd0 && dec_d.rs2 == ld_rd_q));
  assign hazard    = (LOAD_USE_STALL != 0) && in_valid && src_hit && !flush;
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = reset_n && (flush || slot_free) && !hazard;
  assign accept    = in_valid && in_ready;

  assign ld_pend_d = is_ld && (dec_d.rd != 5'd0);
  assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      bnd_q       <= '0;
      ld_pend_q   <= 1'b0;
      ld_rd_q     <= 5'd0;
      cnt_q       <= '0;
    end else if (flush) begin
      // an accepted instruction in this cycle is dropped, not loaded
      out_valid_q <= 1'b0;
      ld_pend_q   <= 1'b0;
    end else if (accept) begin
      bnd_q       <= dec_d;
      out_valid_q <= 1'b1;
      ld_pend_q   <= ld_pend_d;
      ld_rd_q     <= dec_d.rd;
    end else if (hazard && slot_free) begin
      // bubble: the load has moved on, so the dependent accepts next cycle
      out_valid_q <= 1'b0;
      ld_pend_q   <= 1'b0;
      cnt_q       <= cnt_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = bnd_q.pc;
  assign alu_op     = bnd_q.alu_op;
  assign rs1        = bnd_q.rs1;
  assign rs2        = bnd_q.rs2;
  assign rd         = bnd_q.rd;
  assign imm        = bnd_q.imm;
  assign imm_sel    = bnd_q.imm_sel;
  assign mem_rd     = bnd_q.mem_rd;
  assign mem_wr     = bnd_q.mem_wr;
  assign br_eqz     = bnd_q.br_eqz;
  assign br_nez     = bnd_q.br_nez;
  assign jmp_abs    = bnd_q.jmp_abs;
  assign jmp_reg    = bnd_q.jmp_reg;
  assign illegal    = bnd_q.illegal;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Bench for dlx_decode_stage. Instance A: XLEN=64, stall on, 3-bit counter
// (so saturation is reachable). Instance B: XLEN=32, stall off.
// Stimulus pushes hand-computed bundles into per-instance queues; monitors pop
// and compare whenever a bundle is handed to EX.
module tb_dlx_decode_stage;

  localparam logic [7:0] C_IMM = 8'h80, C_MRD = 8'h40, C_MWR = 8'h20,
                         C_BEQ = 8'h10, C_BNE = 8'h08, C_JA  = 8'h04,
                         C_JR  = 8'h02, C_ILL = 8'h01, C_0   = 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr;
  logic [63:0] a_in_pc, a_out_pc, a_imm;
  logic [4:0]  a_alu_op, a_rs1, a_rs2, a_rd;
  logic        a_imm_sel, a_mem_rd, a_mem_wr, a_br_eqz, a_br_nez, a_jmp_abs, a_jmp_reg, a_illegal;
  logic [2:0]  a_bubble_cnt;
  // instance B
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr;
  logic [31:0] b_in_pc, b_out_pc, b_imm;
  logic [4:0]  b_alu_op, b_rs1, b_rs2, b_rd;
  logic        b_imm_sel, b_mem_rd, b_mem_wr, b_br_eqz, b_br_nez, b_jmp_abs, b_jmp_reg, b_illegal;
  logic [15:0] b_bubble_cnt;

  dlx_decode_stage #(.XLEN(64), .LINK_REG(31), .LOAD_USE_STALL(1), .CNT_W(3)) u_a (
    .clk(clk), .reset_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .alu_op(a_alu_op), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .imm(a_imm),
    .imm_sel(a_imm_sel), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .br_eqz(a_br_eqz), .br_nez(a_br_nez), .jmp_abs(a_jmp_abs), .jmp_reg(a_jmp_reg),
    .illegal(a_illegal), .bubble_cnt(a_bubble_cnt));

  dlx_decode_stage #(.XLEN(32), .LINK_REG(31), .LOAD_USE_STALL(0), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .alu_op(b_alu_op), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .imm(b_imm),
    .imm_sel(b_imm_sel), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .br_eqz(b_br_eqz), .br_nez(b_br_nez), .jmp_abs(b_jmp_abs), .jmp_reg(b_jmp_reg),
    .illegal(b_illegal), .bubble_cnt(b_bubble_cnt));

  // expected bundle {pc, alu, rs1, rs2, rd, imm, ctl}; gap = cycles since the
  // previous bundle on that instance, or -1 for don't care
  typedef struct { logic [155:0] v; int gap; } exp_t;
  exp_t qa[$], qb[$];

  int checks = 0, errs = 0;
  int cyc = 0, a_last = 0, b_last = 0;
  logic [63:0]  pa = 64'h8000_0000_0000_1000;
  logic [31:0]  pb = 32'h0000_2000;
  exp_t         ea, eb;
  logic [155:0] acta, actb;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [91:0] mk(input logic [4:0] alu, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic [4:0] rd,
                                     input logic [63:0] imm, input logic [7:0] ctl);
    return {alu, r1, r2, rd, imm, ctl};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      acta = {a_out_pc, a_alu_op, a_rs1, a_rs2, a_rd, a_imm, a_imm_sel, a_mem_rd, a_mem_wr,
              a_br_eqz, a_br_nez, a_jmp_abs, a_jmp_reg, a_illegal};
      checks++;
      if (qa.size() == 0) begin
        errs++;
        $display("FAIL a_unexpected_bundle got %h want none", acta);
      end else begin
        ea = qa.pop_front();
        if (acta !== ea.v) begin
          errs++;
          $display("FAIL a_bundle got %h want %h", acta, ea.v);
        end
        if (ea.gap >= 0) begin
          checks++;
          if (cyc - a_last != ea.gap) begin
            errs++;
            $display("FAIL a_gap got %0d want %0d", cyc - a_last, ea.gap);
          end
        end
      end
      a_last = cyc;
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      actb = {32'h0, b_out_pc, b_alu_op, b_rs1, b_rs2, b_rd, 32'h0, b_imm, b_imm_sel, b_mem_rd,
              b_mem_wr, b_br_eqz, b_br_nez, b_jmp_abs, b_jmp_reg, b_illegal};
      checks++;
      if (qb.size() == 0) begin
        errs++;
        $display("FAIL b_unexpected_bundle got %h want none", actb);
      end else begin
        eb = qb.pop_front();
        if (actb !== eb.v) begin
          errs++;
          $display("FAIL b_bundle got %h want %h", actb, eb.v);
        end
        if (eb.gap >= 0) begin
          checks++;
          if (cyc - b_last != eb.gap) begin
            errs++;
            $display("FAIL b_gap got %0d want %0d", cyc - b_last, eb.gap);
          end
        end
      end
      b_last = cyc;
    end
  end

  // offer one instruction and hold it until accepted (bounded)
  task automatic send(input int d, input logic [31:0] ins, input logic [91:0] rest, input int gap);
    exp_t e;
    int   n;
    logic rdy;
    n     = 0;
    e.gap = gap;
    if (d == 0) begin
      e.v = {pa, rest}; qa.push_back(e);
      a_in_valid = 1'b1; a_in_instr = ins; a_in_pc = pa; pa = pa + 64'd4;
    end else begin
      e.v = {32'h0, pb, rest}; qb.push_back(e);
      b_in_valid = 1'b1; b_in_instr = ins; b_in_pc = pb; pb = pb + 32'd4;
    end
    forever begin
      @(negedge clk);
      rdy = (d == 0) ? a_in_ready : b_in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 20) begin
        checks++; errs++;
        $display("FAIL send_timeout got no in_ready want in_ready within 20 cycles");
        break;
      end
    end
    if (d == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errs++;
      $display("FAIL drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h0; a_in_pc = 64'h0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_instr = 32'h0; b_in_pc = 32'h0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_cnt", 64'(a_bubble_cnt), 64'd0);
    chk("rst_imm", a_imm, 64'd0);
    chk("rst_rd", 64'(a_rd), 64'd0);
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // decode table
    send(0, 32'h00221820, mk(5'd1, 5'd1, 5'd2, 5'd3, 64'h0, C_0), -1);            // ADD
    send(0, 32'h2004FFFF, mk(5'd1, 5'd0, 5'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, C_IMM), 1); // ADDI -1
    send(0, 32'h3027FFFF, mk(5'd3, 5'd1, 5'd0, 5'd7, 64'h0000_0000_0000_FFFF, C_IMM), 1); // ANDI
    send(0, 32'h34228001, mk(5'd4, 5'd1, 5'd0, 5'd2, 64'h8001, C_IMM), -1);       // ORI
    send(0, 32'h00644022, mk(5'd2, 5'd3, 5'd4, 5'd8, 64'h0, C_0), -1);            // SUB
    send(0, 32'h00430804, mk(5'd6, 5'd2, 5'd3, 5'd1, 64'h0, C_0), -1);            // SLL
    send(0, 32'hAC220008, mk(5'd1, 5'd1, 5'd2, 5'd0, 64'h8, C_IMM | C_MWR), -1);  // SW
    send(0, 32'h1460FFFC, mk(5'd9, 5'd3, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, C_BNE), -1);
    send(0, 32'h10200010, mk(5'd8, 5'd1, 5'd0, 5'd0, 64'h10, C_BEQ), -1);         // BEQZ
    send(0, 32'h3C098000, mk(5'd0, 5'd0, 5'd0, 5'd9, 64'h8000, C_IMM), -1);       // LHI
    send(0, 32'h602AFFFE, mk(5'd10, 5'd1, 5'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, C_IMM), -1);
    send(0, 32'h0FFFFFFC, mk(5'd15, 5'd0, 5'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFC, C_JA), -1); // JAL
    send(0, 32'h4C800000, mk(5'd15, 5'd4, 5'd0, 5'd31, 64'h0, C_JR), -1);         // JALR
    send(0, 32'h48E00000, mk(5'd0, 5'd7, 5'd0, 5'd0, 64'h0, C_JR), -1);           // JR
    send(0, 32'hFC000000, mk(5'd0, 5'd0, 5'd0, 5'd0, 64'h0, C_ILL), -1);          // op 3F
    send(0, 32'h0022183F, mk(5'd0, 5'd0, 5'd0, 5'd0, 64'h0, C_ILL), -1);          // bad funct
    drain();
    chk("cnt_after_table", 64'(a_bubble_cnt), 64'd0);

    // load-use on rs1 (R-type)
    send(0, 32'h8C250000, mk(5'd1, 5'd1, 5'd0, 5'd5, 64'h0, C_IMM | C_MRD), -1);
    send(0, 32'h00A23020, mk(5'd1, 5'd5, 5'd2, 5'd6, 64'h0, C_0), 2);
    drain();
    chk("cnt_lu_rs1", 64'(a_bubble_cnt), 64'd1);
    // load-use on SW data register
    send(0, 32'h8C250000, mk(5'd1, 5'd1, 5'd0, 5'd5, 64'h0, C_IMM | C_MRD), -1);
    send(0, 32'hAC250000, mk(5'd1, 5'd1, 5'd5, 5'd0, 64'h0, C_IMM | C_MWR), 2);
    drain();
    chk("cnt_lu_sw", 64'(a_bubble_cnt), 64'd2);
    // LW r0 then use of r0: no stall
    send(0, 32'h8C200000, mk(5'd1, 5'd1, 5'd0, 5'd0, 64'h0, C_IMM | C_MRD), -1);
    send(0, 32'h00023020, mk(5'd1, 5'd0, 5'd2, 5'd6, 64'h0, C_0), 1);
    // LW r5 then J whose rs1 field is 5: J has no sources
    send(0, 32'h8C250000, mk(5'd1, 5'd1, 5'd0, 5'd5, 64'h0, C_IMM | C_MRD), -1);
    send(0, 32'h08A00000, mk(5'd0, 5'd0, 5'd0, 5'd0, 64'h00A0_0000, C_JA), 1);
    // LW r5 then ADDI whose rd field is 5: only rs1 is a source
    send(0, 32'h8C250000, mk(5'd1, 5'd1, 5'd0, 5'd5, 64'h0, C_IMM | C_MRD), -1);
    send(0, 32'h20250001, mk(5'd1, 5'd1, 5'd0, 5'd5, 64'h1, C_IMM), 1);
    drain();
    chk("cnt_no_stall", 64'(a_bubble_cnt), 64'd2);
    // LW r5 then ADDI r6,r5,1: I-type rs1 hazard
    send(0, 32'h8C250000, mk(5'd1, 5'd1, 5'd0, 5'd5, 64'h0, C_IMM | C_MRD), -1);
    send(0, 32'h20A60001, mk(5'd1, 5'd5, 5'd0, 5'd6, 64'h1, C_IMM), 2);
    drain();
    chk("cnt_lu_itype", 64'(a_bubble_cnt), 64'd3);

    // saturation of the 3-bit counter
    for (int i = 0; i < 5; i++) begin
      send(0, 32'h8C250000, mk(5'd1, 5'd1, 5'd0, 5'd5, 64'h0, C_IMM | C_MRD), -1);
      send(0, 32'h00A23020, mk(5'd1, 5'd5, 5'd2, 5'd6, 64'h0, C_0), 2);
      drain();
      if (i == 3) chk("cnt_reach_max", 64'(a_bubble_cnt), 64'd7);
    end
    chk("cnt_saturated", 64'(a_bubble_cnt), 64'd7);

    // back-pressure then flush
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_instr = 32'h00221820; a_in_pc = 64'h40;
    @(negedge clk);
    chk("bp_first_accept", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_instr = 32'h00644022; a_in_pc = 64'h44;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(a_in_ready), 64'd0);
      chk("bp_out_valid", 64'(a_out_valid), 64'd1);
      chk("bp_hold", {a_out_pc[15:0], 11'd0, a_alu_op, a_rs1, a_rs2, a_rd, 12'd0}, {16'h0040, 11'd0, 5'd1, 5'd1, 5'd2, 5'd3, 12'd0});
      @(posedge clk); #1;
    end
    a_flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 64'(a_out_valid), 64'd0);
    end
    chk("flush_cnt", 64'(a_bubble_cnt), 64'd7);
    @(posedge clk); #1;

    // reset while a bundle (a load) is held
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_instr = 32'h8C250000; a_in_pc = 64'h80;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
    chk("midrst_cnt", 64'(a_bubble_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    // the lost load must not leave a pending hazard behind
    send(0, 32'h00A23020, mk(5'd1, 5'd5, 5'd2, 5'd6, 64'h0, C_0), -1);
    drain();
    chk("post_rst_cnt", 64'(a_bubble_cnt), 64'd0);

    // instance B: XLEN=32, stall disabled
    send(1, 32'h8C250000, mk(5'd1, 5'd1, 5'd0, 5'd5, 64'h0, C_IMM | C_MRD), -1);
    send(1, 32'h00A23020, mk(5'd1, 5'd5, 5'd2, 5'd6, 64'h0, C_0), 1);
    send(1, 32'h2004FFFF, mk(5'd1, 5'd0, 5'd0, 5'd4, 64'hFFFF_FFFF, C_IMM), 1);
    send(1, 32'h0FFFFFFC, mk(5'd15, 5'd0, 5'd0, 5'd31, 64'hFFFF_FFFC, C_JA), 1);
    drain();
    chk("b_cnt", 64'(b_bubble_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
